// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared external ALU.
// Define ALU_ARB_OVF_TRAP_EN to enable the sticky overflow trap output.
module alu_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        req1,
  input  logic [31:0] a0,
  input  logic [31:0] b0,
  input  logic [31:0] a1,
  input  logic [31:0] b1,
  input  logic [2:0]  op0,
  input  logic [2:0]  op1,
  output logic        gnt0,
  output logic        gnt1,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_ctrl,
  input  logic [31:0] alu_result,
  input  logic        alu_zero,
  input  logic        alu_o,
  output logic        rsp_valid,
  output logic        rsp_id,
  output logic [31:0] rsp_result,
  output logic        rsp_zero,
  output logic        rsp_ovf,
  input  logic        rsp_ack,
  output logic        busy,
  output logic        ovf_trap
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [2:0] OP_ADD = 3'b100;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_X0  = 3'b010;
  localparam logic [2:0] OP_X1  = 3'b111;

  state_e      state_q, state_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [2:0]  ctrl_q, ctrl_d;
  logic        win_q, win_d;
  logic        last_q, last_d;
  logic        vld_q, vld_d;
  logic        id_q, id_d;
  logic [31:0] res_q, res_d;
  logic        zero_q, zero_d;
  logic        ovf_q, ovf_d;

  logic        any_req;
  logic        pick1;
  logic        illegal;
  logic        ovf_en;
  logic        ovf_now;

  assign any_req = req0 | req1;
  // Requester 1 wins alone, or on contention when 0 was served last.
  assign pick1   = req1 & (~req0 | ~last_q);
  assign illegal = (ctrl_q == OP_X0) | (ctrl_q == OP_X1);
  assign ovf_en  = (ctrl_q == OP_ADD) | (ctrl_q == OP_SUB);
  assign ovf_now = ovf_en & alu_o;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    ctrl_d  = ctrl_q;
    win_d   = win_q;
    last_d  = last_q;
    vld_d   = vld_q;
    id_d    = id_q;
    res_d   = res_q;
    zero_d  = zero_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          win_d   = pick1;
          a_d     = pick1 ? a1 : a0;
          b_d     = pick1 ? b1 : b0;
          ctrl_d  = pick1 ? op1 : op0;
          state_d = EXEC;
        end
      end
      EXEC: begin
        vld_d   = 1'b1;
        id_d    = win_q;
        state_d = RESP;
        unique case (1'b1)
          illegal: begin
            res_d  = 32'd0;
            zero_d = 1'b1;
            ovf_d  = 1'b0;
          end
          default: begin
            res_d  = alu_result;
            zero_d = alu_zero;
            ovf_d  = ovf_now;
          end
        endcase
      end
      RESP: begin
        if (rsp_ack) begin
          vld_d   = 1'b0;
          last_d  = win_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      ctrl_q  <= '0;
      win_q   <= 1'b0;
      last_q  <= 1'b1;
      vld_q   <= 1'b0;
      id_q    <= 1'b0;
      res_q   <= '0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      ctrl_q  <= ctrl_d;
      win_q   <= win_d;
      last_q  <= last_d;
      vld_q   <= vld_d;
      id_q    <= id_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
      ovf_q   <= ovf_d;
    end
  end

`ifdef ALU_ARB_OVF_TRAP_EN
  logic trap_q, trap_d;

  always_comb begin
    trap_d = trap_q;
    if (state_q == EXEC && !illegal && ovf_now) begin
      trap_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trap_q <= 1'b0;
    end else begin
      trap_q <= trap_d;
    end
  end

  assign ovf_trap = trap_q;
`else
  assign ovf_trap = 1'b0;
`endif

  assign gnt0       = (state_q == EXEC) & ~win_q;
  assign gnt1       = (state_q == EXEC) & win_q;
  assign busy       = (state_q != IDLE);
  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign alu_ctrl   = ctrl_q;
  assign rsp_valid  = vld_q;
  assign rsp_id     = id_q;
  assign rsp_result = res_q;
  assign rsp_zero   = zero_q;
  assign rsp_ovf    = ovf_q;

endmodule
